gray_sync_decoder: RTL and testbench
====================================

// Module: gray_sync_decoder
// PURPOSE
//  Receiver stage that consumes a Gray-coded count produced by a bin2gray encoder in another clock domain.
//  Synchronises the Gray word into the local clock domain and converts it back to binary.
//  Detects each code change and classifies it: up, down, wrap, or illegal multi-bit step.
//  Intended use: decoding FIFO pointers or position counters sent across clock domains.
// PARAMETERS
//  WIDTH        4  bit width of the Gray/binary word (>=2)
//  SYNC_STAGES  2  number of synchroniser flops on gray_in (>=2)
// PORTS
//  clk         input   1      single clock; all logic rising-edge
//  rst_n       input   1      reset, synchronous, active-low
//  gray_in     input   WIDTH  Gray code from upstream encoder; asynchronous to clk
//  enable      input   1      1 = compare/update stage active; 0 = outputs hold
//  gray_sync   output  WIDTH  last Gray value accepted by the compare stage
//  binary_out  output  WIDTH  binary equivalent of gray_sync
//  valid       output  1      1-cycle pulse: a new code was accepted this cycle
//  dir         output  1      1 = last legal step was +1, 0 = -1 (mod 2^WIDTH)
//  wrap        output  1      1-cycle pulse: legal step crossed 2^WIDTH-1 <-> 0
//  step_err    output  1      1-cycle pulse: accepted code differs in >1 bit
//  err_sticky  output  1      set by any step_err; cleared only by reset
// BEHAVIOUR
//  Reset (rst_n=0 at a rising edge): clears every sync flop and every output to 0.
//   - The reset state is gray_sync=0, binary_out=0, dir=0, err_sticky=0, pulses=0.
//  Sync chain: SYNC_STAGES flops s[0..S-1]; runs every cycle, independent of enable.
//   - s[0] samples gray_in; s[S-1] is the synchronised value g_s.
//  Conversion: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i], applied combinationally to g_s.
//  Compare stage, at each edge with rst_n=1, enable=1, and g_s != gray_sync:
//   - gray_sync <= g_s; binary_out <= bin(g_s); valid <= 1.
//   - If popcount(g_s ^ gray_sync) == 1 (legal step):
//     - dir <= 1 if bin(g_s) == binary_out+1 mod 2^W, else dir <= 0.
//     - wrap <= 1 if the step is 2^W-1 -> 0 or 0 -> 2^W-1.
//   - If popcount > 1 (illegal step): step_err <= 1; err_sticky <= 1; dir holds; wrap <= 0.
//  Otherwise (enable=0, or no change): valid, wrap and step_err are 0; all other outputs hold.
//  Latency: a gray_in change first sampled at edge N updates outputs at edge N+SYNC_STAGES.
//   - Applies only if enable=1 at that edge.
//  enable low: changes are not lost.
//   - At the first edge with enable=1, the current g_s is compared with gray_sync.
//   - Multiple legal steps taken while enable was low therefore report step_err.
//  Steady gray_in: no pulses are generated.
//  Back-to-back changes on consecutive cycles give back-to-back valid pulses.
//  After reset, a nonzero gray_in is reported as a step from 0 and is classified as above.
//  Reset mid-operation has priority over everything: all state returns to 0 in the same edge.
//   - err_sticky is cleared.
// TESTING
//  T1 reset: gray_in=0110, rst_n=0 for 3 edges -> all outputs 0; the same 3 edges with rst_n=1 -> step_err=1.
//  T2 latency: from reset, gray_in 0000->0001 before edge N, enable=1
//   -> valid=1, binary_out=0001, dir=1 at edge N+2, for exactly 1 cycle.
//  T3 full count: drive gray(0..15, 0), each held 4 cycles
//   -> 16 valid pulses, binary_out follows 1..15,0, dir=1, wrap=1 only on 1000->0000, step_err never set.
//  T4 down and wrap: gray 0011->0001 gives binary 2->1, dir=0, no wrap.
//   - gray 0000->1000 gives binary 0->15, dir=0, wrap=1.
//  T5 illegal: gray 0000->0011 -> valid=1, step_err=1, binary_out=0010, err_sticky=1.
//   - err_sticky stays 1 through later legal steps until rst_n=0.
//  T6 enable: enable=0 while gray goes 0000->0001->0011; set enable=1
//   -> one valid at the first enabled edge, binary_out=0010, step_err=1.
//   - Then rst_n=0 for one edge mid-stream -> all outputs 0 on that edge.

Source files
------------

// File: rtl/gray_sync_decoder_if.sv
// Bundle between a Gray-count receiver and its user: the asynchronous Gray word
// and enable coming in, plus the decoded and classified results going out.
interface gray_sync_decoder_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] gray_in;
    logic             enable;
    logic [WIDTH-1:0] gray_sync;
    logic [WIDTH-1:0] binary_out;
    logic             valid;
    logic             dir;
    logic             wrap;
    logic             step_err;
    logic             err_sticky;

    modport master (
        output gray_in, enable,
        input  gray_sync, binary_out, valid, dir, wrap, step_err, err_sticky
    );

    modport slave (
        input  gray_in, enable,
        output gray_sync, binary_out, valid, dir, wrap, step_err, err_sticky
    );
endinterface

// File: rtl/gray_sync_decoder.sv
// Synchronises a Gray-coded count from another clock domain, decodes it to binary
// and classifies every accepted code change as up, down, wrap or multi-bit error.
module gray_sync_decoder #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gray_sync_decoder_if.slave   bus
);
    localparam logic [WIDTH-1:0] MAX_CODE = '1;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] binary_q;
    logic             valid_q;
    logic             dir_q;
    logic             wrap_q;
    logic             step_err_q;
    logic             err_sticky_q;

    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] bin_s;
    logic [WIDTH-1:0] diff;
    logic             changed;
    logic             legal;
    logic             is_up;
    logic             is_wrap;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Classify the synchronised code against the last accepted one
    always_comb begin
        g_s     = sync_q[SYNC_STAGES-1];
        bin_s   = gray2bin(g_s);
        diff    = g_s ^ gray_q;
        changed = (diff != '0);
        legal   = $onehot(diff);
        is_up   = (bin_s == WIDTH'(binary_q + 1'b1));
        is_wrap = ((binary_q == MAX_CODE) && (bin_s == '0)) ||
                  ((binary_q == '0) && (bin_s == MAX_CODE));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q       <= '0;
            gray_q       <= '0;
            binary_q     <= '0;
            valid_q      <= 1'b0;
            dir_q        <= 1'b0;
            wrap_q       <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.gray_in};
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            step_err_q <= 1'b0;
            // Changes seen while disabled stay pending in g_s until enable returns
            if (bus.enable && changed) begin
                gray_q   <= g_s;
                binary_q <= bin_s;
                valid_q  <= 1'b1;
                if (legal) begin
                    dir_q  <= is_up;
                    wrap_q <= is_wrap;
                end else begin
                    step_err_q   <= 1'b1;
                    err_sticky_q <= 1'b1;
                end
            end
        end
    end

    assign bus.gray_sync  = gray_q;
    assign bus.binary_out = binary_q;
    assign bus.valid      = valid_q;
    assign bus.dir        = dir_q;
    assign bus.wrap       = wrap_q;
    assign bus.step_err   = step_err_q;
    assign bus.err_sticky = err_sticky_q;
endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder: step table plus reset, latency, full-count
// and enable-hold sequences.
module tb_gray_sync_decoder;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    gray_sync_decoder_if #(.WIDTH(4)) bus ();

    gray_sync_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gray;
        logic [3:0] bin;
        logic       dir;
        logic       wrap;
        logic       err;
        logic       sticky;
    } vec_t;

    vec_t vecs [9];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] g, input logic [3:0] b,
                             input logic v, input logic d, input logic w,
                             input logic e, input logic s);
        check({name, ".gray_sync"},  32'(bus.gray_sync),  32'(g));
        check({name, ".binary_out"}, 32'(bus.binary_out), 32'(b));
        check({name, ".valid"},      32'(bus.valid),      32'(v));
        check({name, ".dir"},        32'(bus.dir),        32'(d));
        check({name, ".wrap"},       32'(bus.wrap),       32'(w));
        check({name, ".step_err"},   32'(bus.step_err),   32'(e));
        check({name, ".err_sticky"}, 32'(bus.err_sticky), 32'(s));
    endtask

    task automatic do_reset();
        bus.gray_in = 4'b0000;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    int valids;
    int wraps;
    int errs;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        bus.enable  = 1'b1;
        bus.gray_in = 4'b0110;

        // Step table from reset; each entry is one code change with enable high
        vecs[0] = '{gray: 4'b0001, bin: 4'd1,  dir: 1'b1, wrap: 1'b0, err: 1'b0, sticky: 1'b0};
        vecs[1] = '{gray: 4'b0011, bin: 4'd2,  dir: 1'b1, wrap: 1'b0, err: 1'b0, sticky: 1'b0};
        vecs[2] = '{gray: 4'b0001, bin: 4'd1,  dir: 1'b0, wrap: 1'b0, err: 1'b0, sticky: 1'b0};
        vecs[3] = '{gray: 4'b0000, bin: 4'd0,  dir: 1'b0, wrap: 1'b0, err: 1'b0, sticky: 1'b0};
        vecs[4] = '{gray: 4'b1000, bin: 4'd15, dir: 1'b0, wrap: 1'b1, err: 1'b0, sticky: 1'b0};
        vecs[5] = '{gray: 4'b0000, bin: 4'd0,  dir: 1'b1, wrap: 1'b1, err: 1'b0, sticky: 1'b0};
        vecs[6] = '{gray: 4'b0011, bin: 4'd2,  dir: 1'b1, wrap: 1'b0, err: 1'b1, sticky: 1'b1};
        vecs[7] = '{gray: 4'b0010, bin: 4'd3,  dir: 1'b1, wrap: 1'b0, err: 1'b0, sticky: 1'b1};
        vecs[8] = '{gray: 4'b0110, bin: 4'd4,  dir: 1'b1, wrap: 1'b0, err: 1'b0, sticky: 1'b1};

        // T1: reset with a nonzero input, then the pending code shows as an illegal step
        rst_n = 1'b0;
        tick(3);
        check_out("t1_reset", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(2);
        check("t1_no_early_valid", 32'(bus.valid), 32'd0);
        tick(1);
        check_out("t1_after", 4'b0110, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        // Table: latency of 3 ticks from drive, single-cycle pulses
        do_reset();
        check_out("tbl_reset", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            bus.gray_in = vecs[k].gray;
            tick(2);
            check($sformatf("tbl%0d.early_valid", k), 32'(bus.valid), 32'd0);
            tick(1);
            check_out($sformatf("tbl%0d", k), vecs[k].gray, vecs[k].bin, 1'b1,
                      vecs[k].dir, vecs[k].wrap, vecs[k].err, vecs[k].sticky);
            tick(1);
            check($sformatf("tbl%0d.valid_drop", k), 32'(bus.valid), 32'd0);
            check($sformatf("tbl%0d.wrap_drop", k), 32'(bus.wrap), 32'd0);
            check($sformatf("tbl%0d.err_drop", k), 32'(bus.step_err), 32'd0);
        end

        // T3: full count 1..15,0 each held 4 cycles
        do_reset();
        valids = 0;
        wraps  = 0;
        errs   = 0;
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] b;
            b = 4'(i);
            bus.gray_in = b ^ (b >> 1);
            for (int c = 0; c < 4; c++) begin
                tick(1);
                if (bus.valid)    valids++;
                if (bus.wrap)     wraps++;
                if (bus.step_err) errs++;
                if (c == 2) begin
                    check($sformatf("t3_%0d.valid", i), 32'(bus.valid), 32'd1);
                    check($sformatf("t3_%0d.bin", i), 32'(bus.binary_out), 32'(b));
                    check($sformatf("t3_%0d.dir", i), 32'(bus.dir), 32'd1);
                    check($sformatf("t3_%0d.wrap", i), 32'(bus.wrap), 32'(i == 16));
                end
            end
        end
        check("t3_valid_count", 32'(valids), 32'd16);
        check("t3_wrap_count", 32'(wraps), 32'd1);
        check("t3_err_count", 32'(errs), 32'd0);
        check("t3_sticky", 32'(bus.err_sticky), 32'd0);

        // Steady input produces no pulses
        tick(5);
        check_out("steady", 4'b0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // T6: two legal steps while disabled become one illegal step on enable
        do_reset();
        bus.enable  = 1'b0;
        bus.gray_in = 4'b0001;
        tick(3);
        bus.gray_in = 4'b0011;
        tick(3);
        check_out("t6_hold", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.enable = 1'b1;
        tick(1);
        check_out("t6_enable", 4'b0011, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(1);
        check("t6_valid_drop", 32'(bus.valid), 32'd0);
        // Back-to-back changes give back-to-back pulses
        bus.gray_in = 4'b0010;
        tick(1);
        bus.gray_in = 4'b0110;
        tick(2);
        check_out("b2b_first", 4'b0010, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1);
        check_out("b2b_second", 4'b0110, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        // Mid-stream reset clears everything including the sticky flag
        bus.gray_in = 4'b0111;
        tick(1);
        rst_n = 1'b0;
        tick(1);
        check_out("t6_reset", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
